// File: rtl/layer_mem_arbiter_pkg.sv
// Shared definitions for the layer-memory arbiter.
//   - arbiter state encoding (S_ARB_IDLE / S_ARB_OWN / S_ARB_DRAIN)
//   - requester index constants (REQ_CONV / REQ_POOL / REQ_FLAT)
//   - memory widths (LAYER_W, MEM_ADDR_W, MEM_DATA_W) and READ_MEM_DELAY
//   - wrap_inc: modulo-N increment of a requester index
package layer_mem_arbiter_pkg;

  localparam int LAYER_W        = 3;
  localparam int MEM_ADDR_W     = 12;
  localparam int MEM_DATA_W     = 20;
  localparam int READ_MEM_DELAY = 1;

  // Requester index width; grant_id is two bits wide, so at most 4 requesters.
  localparam int IDX_W = 2;

  localparam logic [IDX_W-1:0] REQ_CONV = 2'd0;
  localparam logic [IDX_W-1:0] REQ_POOL = 2'd1;
  localparam logic [IDX_W-1:0] REQ_FLAT = 2'd2;

  typedef enum logic [1:0] {
    S_ARB_IDLE  = 2'd0,
    S_ARB_OWN   = 2'd1,
    S_ARB_DRAIN = 2'd2
  } arb_state_t;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    int t;
    t = int'(idx) + 1;
    return (t >= n) ? '0 : IDX_W'(t);
  endfunction

endpackage

// File: rtl/layer_mem_arbiter_rr_pick.sv
// rr_pick: picks one requester from a request vector, searching upward from
// a start index and wrapping modulo N_REQ. A start index of 0 gives fixed
// priority (lowest index wins).
// Ports:
//   i_req    in  N_REQ   request vector
//   i_start  in  IDX_W   first index searched
//   o_grant  out N_REQ   one-hot winner (0 when no request)
//   o_idx    out IDX_W   winner index
//   o_any    out 1       at least one request present
module rr_pick
  import layer_mem_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int unsigned c;
    c       = '0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      c = 32'(i_start) + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (!o_any && (((i_req >> c) & N_REQ'(1)) != '0)) begin
        o_any   = 1'b1;
        o_idx   = IDX_W'(c);
        o_grant = N_REQ'(1) << c;
      end
    end
  end

endmodule

// File: rtl/layer_mem_arbiter.sv
// layer_mem_arbiter: shares the single layer-memory port among N_REQ
// datapath requesters (0 = conv, 1 = pool, 2 = flat). A grant is held from
// arbitration until the accepted beat carrying req_last. Accepted beats are
// registered onto the memory pins one cycle later; read responses are routed
// back to the issuing requester by a tag travelling alongside crd.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with the lowest index winning.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_last/req_we [N_REQ]   per-requester beat controls
//   req_sel/req_addr/req_wdata          packed per-requester fields, req 0 in LSBs
//   req_ready [N_REQ]                   beat accepted when valid & ready
//   rsp_valid [N_REQ], rsp_data         read return, shared data bus
//   csel, caddr_wr, cdata_wr, cwr       registered memory write side
//   caddr_rd, crd                       registered memory read side
//   cdata_rd                            memory read data
//   grant_id                            current owner, meaningful in OWN
module layer_mem_arbiter
  import layer_mem_arbiter_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int SEL_W  = LAYER_W,
  parameter int RD_LAT = READ_MEM_DELAY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_last,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*SEL_W-1:0]  req_sel,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [SEL_W-1:0]    csel,
  output logic [ADDR_W-1:0]   caddr_wr,
  output logic [DATA_W-1:0]   cdata_wr,
  output logic                cwr,
  output logic [ADDR_W-1:0]   caddr_rd,
  output logic                crd,
  input  logic [DATA_W-1:0]   cdata_rd,
  output logic [1:0]          grant_id
);

  arb_state_t r_state, w_next;

  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_last_owner;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_pick_idx;
  logic [N_REQ-1:0] w_pick_grant;
  logic             w_pick_any;
  logic             w_same_owner;
  logic             w_acc;
  logic             w_release;
  logic             w_pending;

  logic [SEL_W-1:0]  w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  logic [SEL_W-1:0]  r_csel;
  logic [ADDR_W-1:0] r_caddr_wr;
  logic [DATA_W-1:0] r_cdata_wr;
  logic              r_cwr;
  logic [ADDR_W-1:0] r_caddr_rd;
  logic              r_crd;
  logic [IDX_W-1:0]  r_rd_tag;

  // Tag pipe: stage k holds reads issued k+1 cycles ago; the last stage lines
  // up with cdata_rd.
  logic [RD_LAT-1:0]       r_pipe_vld;
  logic [RD_LAT*IDX_W-1:0] r_pipe_tag;
  logic                    w_rsp_vld;
  logic [IDX_W-1:0]        w_rsp_tag;

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0] r_rr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (w_release) begin
      r_rr_ptr <= wrap_inc(r_owner, N_REQ);
    end
  end

  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req   (req_valid),
    .i_start (w_start),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_same_owner = |(w_pick_grant & (N_REQ'(1) << r_last_owner));
  assign w_acc        = (r_state == S_ARB_OWN) && req_valid[r_owner];
  assign w_release    = w_acc && req_last[r_owner];

  // A read still owed to a requester after this cycle; the one returning in
  // the current cycle does not hold off a new owner.
  assign w_pending = r_crd | (|(r_pipe_vld & ~(RD_LAT'(1) << (RD_LAT - 1))));

  assign w_sel   = SEL_W'(req_sel >> (int'(r_owner) * SEL_W));
  assign w_addr  = ADDR_W'(req_addr >> (int'(r_owner) * ADDR_W));
  assign w_wdata = DATA_W'(req_wdata >> (int'(r_owner) * DATA_W));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_ARB_IDLE: begin
        if (w_pick_any) begin
          w_next = (w_pending && !w_same_owner) ? S_ARB_DRAIN : S_ARB_OWN;
        end
      end
      S_ARB_DRAIN: begin
        if (!w_pending) w_next = S_ARB_OWN;
      end
      S_ARB_OWN: begin
        if (w_release) w_next = S_ARB_IDLE;
      end
      default: w_next = S_ARB_IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    req_ready = '0;
    if (r_state == S_ARB_OWN) req_ready = N_REQ'(1) << r_owner;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner      <= REQ_CONV;
      r_last_owner <= REQ_CONV;
    end else begin
      if (r_state == S_ARB_IDLE && w_pick_any) r_owner <= w_pick_idx;
      if (w_release) r_last_owner <= r_owner;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_csel     <= '0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
      r_cwr      <= 1'b0;
      r_caddr_rd <= '0;
      r_crd      <= 1'b0;
      r_rd_tag   <= '0;
      r_pipe_vld <= '0;
      r_pipe_tag <= '0;
    end else begin
      r_cwr <= 1'b0;
      r_crd <= 1'b0;
      if (w_acc) begin
        r_csel <= w_sel;
        if (req_we[r_owner]) begin
          r_cwr      <= 1'b1;
          r_caddr_wr <= w_addr;
          r_cdata_wr <= w_wdata;
        end else begin
          r_crd      <= 1'b1;
          r_caddr_rd <= w_addr;
          r_rd_tag   <= r_owner;
        end
      end
      r_pipe_vld <= (r_pipe_vld << 1) | RD_LAT'(r_crd);
      r_pipe_tag <= (r_pipe_tag << IDX_W) | (RD_LAT * IDX_W)'(r_rd_tag);
    end
  end

  assign w_rsp_vld = r_pipe_vld[RD_LAT-1];
  assign w_rsp_tag = IDX_W'(r_pipe_tag >> ((RD_LAT - 1) * IDX_W));

  assign rsp_valid = w_rsp_vld ? (N_REQ'(1) << w_rsp_tag) : '0;
  assign rsp_data  = w_rsp_vld ? cdata_rd : '0;

  assign csel     = r_csel;
  assign caddr_wr = r_caddr_wr;
  assign cdata_wr = r_cdata_wr;
  assign cwr      = r_cwr;
  assign caddr_rd = r_caddr_rd;
  assign crd      = r_crd;
  assign grant_id = r_owner;

endmodule
